syn_sum_acc: RTL and testbench
==============================

Name: syn_sum_acc

Overview:
- Downstream consumer of the adder stage's {cout, sum[7:0]} result.
- Accumulates N_SAMPLES 9-bit results into one wide frame total and presents it with a valid/ready handshake.
- Holds the result until the sink accepts it.
- Provides a saturation flag and a wrapping frame counter for downstream control/debug.

Parameters:
- N_SAMPLES, 4, results summed per frame; legal range 1..255.
- ACC_W, 12, accumulator/result width; legal range 9..32.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- in_valid  input  1  sum/cout carry a valid adder result this cycle.
- sum  input  8  adder sum.
- cout  input  1  adder carry-out.
- in_ready  output  1  block can accept a sample this cycle.
- out_ready  input  1  sink accepts the result.
- out_valid  output  1  acc_out/ovf hold a completed frame.
- acc_out  output  ACC_W  frame total.
- ovf  output  1  frame total saturated.
- frame_cnt  output  8  count of frames handed off; wraps.

Behaviour:
- Sample value = {cout, sum}, 9 bits, zero-extended to ACC_W+1 bits for the addition.
- Reset value of every output: in_ready=1, out_valid=0, acc_out=0, ovf=0, frame_cnt=0.
- Reset value of internal state: state=ACC, acc=0, cnt=0, sat=0.
- FSM has two states, ACC and HOLD.
- ACC state:
  - in_ready=1.
  - Accept = in_valid & in_ready, sampled on the rising edge.
  - On accept, compute s = acc + sample at ACC_W+1 bits.
  - If s[ACC_W]=1, or sat is already set, acc saturates to all-ones and sat is set.
  - cnt increments by 1 on each accept.
- Frame completion, on the accept where cnt == N_SAMPLES-1:
  - acc_out <= saturated s.
  - ovf <= sat | s[ACC_W].
  - acc, cnt and sat clear.
  - state <= HOLD; out_valid=1 from the next cycle.
  - Latency: result visible one cycle after the final accepting edge.
- HOLD state:
  - in_ready=0; in_valid is ignored and no sample is consumed.
  - acc_out and ovf are stable while out_valid=1.
  - On out_valid & out_ready at an edge: out_valid <= 0, state <= ACC, frame_cnt <= frame_cnt+1.
  - frame_cnt wraps 255 to 0.
  - in_ready returns to 1 in the cycle after the handshake, so there is one bubble per frame.
- out_ready=1 while in ACC state has no effect.
- N_SAMPLES=1: every accept completes a frame; the block alternates ACC/HOLD.
- in_valid gaps (in_valid=0) in ACC: acc and cnt hold, with no timeout.
- Reset mid-frame or mid-HOLD:
  - Partial accumulation is discarded.
  - out_valid drops asynchronously.
  - After rst deasserts, the first rising edge with in_valid=1 counts as sample 1.
- cnt width = clog2(N_SAMPLES), minimum 1 bit.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
1. Defaults. rst=0 for 2 cycles, then 1; drive sum=3, cout=0, in_valid=1 for 4 cycles, out_ready=0.
   - Required: acc_out=12, ovf=0, out_valid=1 one cycle after the 4th accept.
   - in_ready=0 while held; frame_cnt=0 until out_ready=1.
   - After the handshake: frame_cnt=1, in_ready=1 on the following cycle.
2. Carry in sample. Four samples with sum=255, cout=1 (value 511).
   - Required: acc_out=2044, ovf=0.
3. Saturation, ACC_W=10. Four samples of value 511.
   - Required: acc_out=1023, ovf=1.
   - Next frame of four samples of value 1: acc_out=4, ovf=0 (sat cleared per frame).
4. Gaps and held result.
   - Samples 1, 2, 3, 4 with in_valid=0 gaps of 3 cycles between them: acc_out=10.
   - During HOLD, drive in_valid=1, sum=99 for 5 cycles, then out_ready=1.
   - Next frame of samples 2, 2, 2, 2 gives acc_out=8; the value 99 was never accumulated.
5. Async reset mid-frame. After 2 accepted samples of 50, pull rst=0 between clock edges.
   - Required: out_valid=0, in_ready=1 and frame_cnt=0 immediately.
   - Then four samples of 5: acc_out=20.
6. Wrap, with N_SAMPLES=1 and out_ready held at 1. Stream 256 samples of value 1.
   - Each frame has acc_out=1 and one bubble cycle.
   - frame_cnt reaches 255, then 0 after the 256th handshake.

Source files
------------

// File: rtl/syn_sum_acc.sv
// Frame accumulator: sums N_SAMPLES {cout,sum} adder results with sticky saturation
// and hands each frame total to a valid/ready sink, counting completed hand-offs.
module syn_sum_acc #(
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned ACC_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       sum,
  input  logic             cout,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_acc_out;
  logic               r_ovf;
  logic [7:0]         r_frame_cnt;

  logic [SUM_W-1:0]   w_sample;
  logic [SUM_W-1:0]   w_s;
  logic               w_sat;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_accept;

  // One extra bit of headroom catches the overflow; saturation is sticky within a frame.
  assign w_sample   = SUM_W'({cout, sum});
  assign w_s        = SUM_W'(r_acc) + w_sample;
  assign w_sat      = r_sat | w_s[ACC_W];
  assign w_acc_next = w_sat ? {ACC_W{1'b1}} : w_s[ACC_W-1:0];
  assign w_accept   = in_valid & r_in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_acc_out   <= '0;
      r_ovf       <= 1'b0;
      r_frame_cnt <= '0;
    end else if (r_state == ST_ACC) begin
      if (w_accept) begin
        if (r_cnt == LAST_CNT) begin
          r_acc_out   <= w_acc_next;
          r_ovf       <= w_sat;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_sat       <= 1'b0;
          r_state     <= ST_HOLD;
          r_out_valid <= 1'b1;
          r_in_ready  <= 1'b0;
        end else begin
          r_acc <= w_acc_next;
          r_sat <= w_sat;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end else begin
      // Result stays frozen until the sink takes it; input is refused meanwhile.
      if (out_ready) begin
        r_out_valid <= 1'b0;
        r_in_ready  <= 1'b1;
        r_state     <= ST_ACC;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign acc_out   = r_acc_out;
  assign ovf       = r_ovf;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_syn_sum_acc.sv
// Bench for syn_sum_acc: three parameterisations share one stimulus stream and are
// compared every cycle against a frame-level reference model.
module tb_syn_sum_acc;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] sum;
  logic       cout;
  logic       out_ready;

  logic       o_irdy [3];
  logic       o_ovld [3];
  logic       o_ovf  [3];
  logic [7:0] o_fc   [3];
  logic [11:0] acc0;
  logic [9:0]  acc1;
  logic [11:0] acc2;
  logic [31:0] o_acc [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Instance parameters: frame length and saturation ceiling.
  int P_N   [3] = '{4, 4, 1};
  int P_MAX [3] = '{4095, 1023, 4095};

  // Reference model state (frame-level view, not register-level).
  int m_tot [3];
  int m_n   [3];
  int m_fc  [3];
  int m_out [3];
  bit m_vld [3];
  bit m_rdy [3];
  bit m_ovf [3];

  syn_sum_acc #(.N_SAMPLES(4), .ACC_W(12)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .cout(cout),
    .in_ready(o_irdy[0]), .out_ready(out_ready), .out_valid(o_ovld[0]),
    .acc_out(acc0), .ovf(o_ovf[0]), .frame_cnt(o_fc[0]));

  syn_sum_acc #(.N_SAMPLES(4), .ACC_W(10)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .cout(cout),
    .in_ready(o_irdy[1]), .out_ready(out_ready), .out_valid(o_ovld[1]),
    .acc_out(acc1), .ovf(o_ovf[1]), .frame_cnt(o_fc[1]));

  syn_sum_acc #(.N_SAMPLES(1), .ACC_W(12)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .cout(cout),
    .in_ready(o_irdy[2]), .out_ready(out_ready), .out_valid(o_ovld[2]),
    .acc_out(acc2), .ovf(o_ovf[2]), .frame_cnt(o_fc[2]));

  assign o_acc[0] = 32'(acc0);
  assign o_acc[1] = 32'(acc1);
  assign o_acc[2] = 32'(acc2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_tot[k] = 0; m_n[k] = 0; m_fc[k] = 0; m_out[k] = 0;
      m_vld[k] = 1'b0; m_rdy[k] = 1'b1; m_ovf[k] = 1'b0;
    end
  endtask

  // Frame total saturates iff the plain sum exceeds the ceiling (partial sums only grow).
  task automatic model_edge();
    int smp;
    smp = {23'd0, cout, sum};
    for (int k = 0; k < 3; k++) begin
      if (m_vld[k]) begin
        if (out_ready) begin
          m_vld[k] = 1'b0;
          m_rdy[k] = 1'b1;
          m_fc[k]  = (m_fc[k] + 1) % 256;
        end
      end else if (in_valid && m_rdy[k]) begin
        m_tot[k] += smp;
        m_n[k]++;
        if (m_n[k] == P_N[k]) begin
          m_out[k] = (m_tot[k] > P_MAX[k]) ? P_MAX[k] : m_tot[k];
          m_ovf[k] = (m_tot[k] > P_MAX[k]);
          m_tot[k] = 0;
          m_n[k]   = 0;
          m_vld[k] = 1'b1;
          m_rdy[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_in_ready", k), 32'(o_irdy[k]), 32'(m_rdy[k]));
      chk($sformatf("u%0d_out_valid", k), 32'(o_ovld[k]), 32'(m_vld[k]));
      chk($sformatf("u%0d_frame_cnt", k), 32'(o_fc[k]), 32'(m_fc[k]));
      if (m_vld[k]) begin
        chk($sformatf("u%0d_acc_out", k), o_acc[k], 32'(m_out[k]));
        chk($sformatf("u%0d_ovf", k), 32'(o_ovf[k]), 32'(m_ovf[k]));
      end
    end
  endtask

  // Apply inputs in the low phase, clock once, then compare on the falling edge.
  task automatic step(input logic v, input logic [7:0] s, input logic c, input logic r);
    in_valid  = v;
    sum       = s;
    cout      = c;
    out_ready = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_rst_out_valid", k), 32'(o_ovld[k]), 32'd0);
      chk($sformatf("u%0d_rst_in_ready", k), 32'(o_irdy[k]), 32'd1);
      chk($sformatf("u%0d_rst_frame_cnt", k), 32'(o_fc[k]), 32'd0);
    end
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; sum = '0; cout = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_acc_out", o_acc[0], 32'd0);
    chk("rst_ovf", 32'(o_ovf[0]), 32'd0);
    rst = 1'b1;

    // Defaults: four samples of 3, held until the sink accepts.
    repeat (4) step(1'b1, 8'd3, 1'b0, 1'b0);
    chk("t1_acc", o_acc[0], 32'd12);
    chk("t1_valid", 32'(o_ovld[0]), 32'd1);
    repeat (2) step(1'b1, 8'd3, 1'b0, 1'b0);
    chk("t1_fc_held", 32'(o_fc[0]), 32'd0);
    chk("t1_irdy_held", 32'(o_irdy[0]), 32'd0);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("t1_fc_after", 32'(o_fc[0]), 32'd1);
    chk("t1_irdy_after", 32'(o_irdy[0]), 32'd1);

    // Carry-in samples of 511; the 10-bit instance saturates.
    repeat (4) step(1'b1, 8'd255, 1'b1, 1'b0);
    chk("t2_acc", o_acc[0], 32'd2044);
    chk("t2_ovf", 32'(o_ovf[0]), 32'd0);
    chk("t3_acc_sat", o_acc[1], 32'd1023);
    chk("t3_ovf_sat", 32'(o_ovf[1]), 32'd1);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    repeat (4) step(1'b1, 8'd1, 1'b0, 1'b0);
    chk("t3_acc_clr", o_acc[1], 32'd4);
    chk("t3_ovf_clr", 32'(o_ovf[1]), 32'd0);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Gapped samples, then input offered during HOLD must be ignored.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i < 4) repeat (3) step(1'b0, 8'd0, 1'b0, 1'b0);
    end
    chk("t4_acc_gap", o_acc[0], 32'd10);
    repeat (5) step(1'b1, 8'd99, 1'b0, 1'b0);
    step(1'b1, 8'd99, 1'b0, 1'b1);
    repeat (4) step(1'b1, 8'd2, 1'b0, 1'b0);
    chk("t4_acc_next", o_acc[0], 32'd8);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Asynchronous reset part-way through a frame.
    repeat (2) step(1'b1, 8'd50, 1'b0, 1'b0);
    async_reset();
    repeat (4) step(1'b1, 8'd5, 1'b0, 1'b0);
    chk("t5_acc", o_acc[0], 32'd20);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));

    // Frame counter wrap on the single-sample instance.
    step(1'b0, 8'd0, 1'b0, 1'b1);
    async_reset();
    for (int i = 0; i < 512; i++) begin
      step(1'b1, 8'd1, 1'b0, 1'b1);
      if (i == 509) chk("t6_fc_255", 32'(o_fc[2]), 32'd255);
    end
    chk("t6_fc_wrap", 32'(o_fc[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
